// File: rtl/snoop_step_sequencer.sv
// rtl/snoop_step_sequencer.sv - Round-robin snoop bus controller walking three MESI caches through steps 1..6
module snoop_step_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [14:0] stepDone,
  input  logic [2:0]  instrDone,
  output logic [2:0]  step,
  output logic [2:0]  grant,
  output logic [1:0]  owner,
  output logic        flagClear,
  output logic [2:0]  ack,
  output logic        busy,
  output logic        abortPulse,
  output logic        timeoutErr
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_RETIRE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      k, k_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic [1:0]      last_owner, last_nxt;
  logic [1:0]      winner;
  logic [1:0]      owner_nxt;
  logic [2:0]      grant_nxt;
  logic [2:0]      step_nxt;
  logic [2:0]      ack_nxt;
  logic            flag_nxt;
  logic            busy_nxt;
  logic            abort_nxt;
  logic            terr_nxt;

  logic [4:0]      all_done;
  logic            owner_instr;
  logic            step_complete;

  // A step k flag counts only once all three caches have raised it.
  assign all_done    = stepDone[4:0] & stepDone[9:5] & stepDone[14:10];
  // grant is one-hot on the owner throughout ISSUE, so it selects the owner's instrDone.
  assign owner_instr = |(instrDone & grant);

  always_comb begin
    step_complete = 1'b0;
    case (k)
      3'd1:    step_complete = all_done[0];
      3'd2:    step_complete = all_done[1];
      3'd3:    step_complete = all_done[2];
      3'd4:    step_complete = all_done[3];
      3'd5:    step_complete = all_done[4];
      3'd6:    step_complete = owner_instr;
      default: step_complete = 1'b0;
    endcase
  end

  // Round-robin search begins just after the previous owner.
  always_comb begin
    winner = 2'd0;
    case (last_owner)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    wd_nxt    = wd;
    last_nxt  = last_owner;
    owner_nxt = owner;
    grant_nxt = grant;
    ack_nxt   = 3'b000;
    abort_nxt = 1'b0;
    terr_nxt  = timeoutErr;

    case (state)
      S_IDLE: begin
        grant_nxt = 3'b000;
        if (req != 3'b000) begin
          state_nxt = S_CLEAR;
          owner_nxt = winner;
          grant_nxt = 3'b001 << winner;
        end
      end

      S_CLEAR: begin
        state_nxt = S_ISSUE;
        k_nxt     = 3'd1;
        wd_nxt    = '0;
      end

      S_ISSUE: begin
        if (k == 3'd2 && owner_instr) begin
          state_nxt = S_RETIRE;
          ack_nxt   = grant;
        end else if (step_complete) begin
          wd_nxt = '0;
          if (k == 3'd6) begin
            state_nxt = S_RETIRE;
            ack_nxt   = grant;
          end else begin
            k_nxt = k + 3'd1;
          end
        end else if (TIMEOUT > 0 && wd == WD_LAST) begin
          state_nxt = S_RETIRE;
          ack_nxt   = grant;
          abort_nxt = 1'b1;
          terr_nxt  = 1'b1;
        end else if (TIMEOUT > 0) begin
          wd_nxt = wd + WD_W'(1);
        end
      end

      S_RETIRE: begin
        state_nxt = S_IDLE;
        last_nxt  = owner;
        grant_nxt = 3'b000;
      end

      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 3'b000;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_nxt = (state_nxt != S_IDLE);
    flag_nxt = (state_nxt == S_CLEAR) || (state_nxt == S_RETIRE);
    step_nxt = (state_nxt == S_ISSUE) ? k_nxt : 3'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= 3'd0;
      wd         <= '0;
      last_owner <= 2'd2;
      owner      <= 2'd0;
      grant      <= 3'b000;
      step       <= 3'd0;
      flagClear  <= 1'b0;
      ack        <= 3'b000;
      busy       <= 1'b0;
      abortPulse <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      wd         <= wd_nxt;
      last_owner <= last_nxt;
      owner      <= owner_nxt;
      grant      <= grant_nxt;
      step       <= step_nxt;
      flagClear  <= flag_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      abortPulse <= abort_nxt;
      timeoutErr <= terr_nxt;
    end
  end

endmodule
